// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS core: latches decode results, inserts
// load-use and flush bubbles, and forwards EX/MEM and MEM/WB results into the ALU operands.

module id_ex_fwd #(
    parameter int BIT_DEPTH      = 32,
    parameter int LOG_PORT_DEPTH = 5
) (
    input  logic [LOG_PORT_DEPTH-1:0] spec,
    input  logic [BIT_DEPTH-1:0]      reg_val,
    input  logic                      exmem_reg_write,
    input  logic [LOG_PORT_DEPTH-1:0] exmem_dst,
    input  logic [BIT_DEPTH-1:0]      exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [LOG_PORT_DEPTH-1:0] memwb_dst,
    input  logic [BIT_DEPTH-1:0]      memwb_result,
    output logic [BIT_DEPTH-1:0]      operand
);
    logic exmem_hit;
    logic memwb_hit;

    // $zero is hardwired, so a write to it must never be forwarded
    assign exmem_hit = exmem_reg_write && (exmem_dst != '0) && (exmem_dst == spec);
    assign memwb_hit = memwb_reg_write && (memwb_dst != '0) && (memwb_dst == spec);

    always_comb begin
        operand = reg_val;
        if (exmem_hit)
            operand = exmem_result;
        else if (memwb_hit)
            operand = memwb_result;
    end
endmodule

module id_ex_stage #(
    parameter int BIT_DEPTH      = 32,
    parameter int LOG_PORT_DEPTH = 5,
    parameter int ALU_CTRL_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [BIT_DEPTH-1:0]      id_rd1,
    input  logic [BIT_DEPTH-1:0]      id_rd2,
    input  logic [LOG_PORT_DEPTH-1:0] id_rs,
    input  logic [LOG_PORT_DEPTH-1:0] id_rt,
    input  logic [LOG_PORT_DEPTH-1:0] id_rd,
    input  logic [15:0]               id_imm,
    input  logic                      id_reg_write,
    input  logic                      id_mem_to_reg,
    input  logic                      id_mem_write,
    input  logic                      id_alu_src,
    input  logic                      id_reg_dst,
    input  logic [ALU_CTRL_W-1:0]     id_alu_ctrl,
    input  logic                      flush,
    input  logic                      hold,
    input  logic                      exmem_reg_write,
    input  logic [LOG_PORT_DEPTH-1:0] exmem_dst,
    input  logic [BIT_DEPTH-1:0]      exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [LOG_PORT_DEPTH-1:0] memwb_dst,
    input  logic [BIT_DEPTH-1:0]      memwb_result,
    output logic                      load_use_stall,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_to_reg,
    output logic                      ex_mem_write,
    output logic [ALU_CTRL_W-1:0]     ex_alu_ctrl,
    output logic [LOG_PORT_DEPTH-1:0] ex_dst,
    output logic [LOG_PORT_DEPTH-1:0] ex_rs,
    output logic [LOG_PORT_DEPTH-1:0] ex_rt,
    output logic [BIT_DEPTH-1:0]      ex_alu_a,
    output logic [BIT_DEPTH-1:0]      ex_store_data,
    output logic [BIT_DEPTH-1:0]      ex_alu_b
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      mem_to_reg;
        logic                      mem_write;
        logic                      alu_src;
        logic [ALU_CTRL_W-1:0]     alu_ctrl;
        logic [LOG_PORT_DEPTH-1:0] dst;
        logic [LOG_PORT_DEPTH-1:0] rs;
        logic [LOG_PORT_DEPTH-1:0] rt;
        logic [BIT_DEPTH-1:0]      rd1;
        logic [BIT_DEPTH-1:0]      rd2;
        logic [BIT_DEPTH-1:0]      imm;
    } ex_slot_t;

    ex_slot_t ex_q;
    ex_slot_t ex_d;
    logic     bubble;
    logic     ctrl_en;

    logic [NUM_OPS-1:0][LOG_PORT_DEPTH-1:0] fwd_spec;
    logic [NUM_OPS-1:0][BIT_DEPTH-1:0]      fwd_in;
    logic [NUM_OPS-1:0][BIT_DEPTH-1:0]      fwd_out;

    // A load in EX cannot supply its data until MEM/WB, so a dependent decode waits one cycle
    assign load_use_stall = ex_q.valid && ex_q.mem_to_reg && id_valid &&
                            (ex_q.dst != '0) &&
                            ((ex_q.dst == id_rs) || (ex_q.dst == id_rt));

    assign bubble  = flush || load_use_stall;
    assign ctrl_en = id_valid && !bubble;

    always_comb begin
        ex_d            = '0;
        ex_d.valid      = ctrl_en;
        ex_d.reg_write  = ctrl_en && id_reg_write;
        ex_d.mem_to_reg = ctrl_en && id_mem_to_reg;
        ex_d.mem_write  = ctrl_en && id_mem_write;
        ex_d.alu_src    = ctrl_en && id_alu_src;
        ex_d.alu_ctrl   = ctrl_en ? id_alu_ctrl : '0;
        // data fields load even on a bubble; nothing downstream looks at them
        ex_d.dst        = id_reg_dst ? id_rd : id_rt;
        ex_d.rs         = id_rs;
        ex_d.rt         = id_rt;
        ex_d.rd1        = id_rd1;
        ex_d.rd2        = id_rd2;
        ex_d.imm        = {{(BIT_DEPTH-16){id_imm[15]}}, id_imm};
    end

    // hold outranks flush: upstream keeps flush asserted until hold drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else if (!hold)
            ex_q <= ex_d;
    end

    assign fwd_spec[0] = ex_q.rs;
    assign fwd_spec[1] = ex_q.rt;
    assign fwd_in[0]   = ex_q.rd1;
    assign fwd_in[1]   = ex_q.rd2;

    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
            id_ex_fwd #(
                .BIT_DEPTH      (BIT_DEPTH),
                .LOG_PORT_DEPTH (LOG_PORT_DEPTH)
            ) u_fwd (
                .spec            (fwd_spec[g]),
                .reg_val         (fwd_in[g]),
                .exmem_reg_write (exmem_reg_write),
                .exmem_dst       (exmem_dst),
                .exmem_result    (exmem_result),
                .memwb_reg_write (memwb_reg_write),
                .memwb_dst       (memwb_dst),
                .memwb_result    (memwb_result),
                .operand         (fwd_out[g])
            );
        end
    endgenerate

    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_dst        = ex_q.dst;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_alu_a      = fwd_out[0];
    assign ex_store_data = fwd_out[1];
    assign ex_alu_b      = ex_q.alu_src ? ex_q.imm : fwd_out[1];
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: latching, bubbles, hold/flush priority and forwarding.

module tb_id_ex_stage;
    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rd1, id_rd2;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;
    logic        id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_dst;
    logic [3:0]  id_alu_ctrl;
    logic        flush, hold;
    logic        exmem_reg_write;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_dst;
    logic [31:0] memwb_result;
    logic        load_use_stall, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_dst, ex_rs, ex_rt;
    logic [31:0] ex_alu_a, ex_store_data, ex_alu_b;

    int passed = 0;
    int total  = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_ctrl(id_alu_ctrl), .flush(flush), .hold(hold),
        .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_dst(ex_dst), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_alu_a(ex_alu_a),
        .ex_store_data(ex_store_data), .ex_alu_b(ex_alu_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rd1 = 0; id_rd2 = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0;
        id_reg_write = 0; id_mem_to_reg = 0; id_mem_write = 0; id_alu_src = 0; id_reg_dst = 0;
        id_alu_ctrl = 0; flush = 0; hold = 0;
        exmem_reg_write = 0; exmem_dst = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dst = 0; memwb_result = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #3;
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", ex_valid); else passed++;
        total++; if (ex_dst !== 5'd0) $display("FAIL reset_dst got %0d want 0", ex_dst); else passed++;
        total++; if (ex_alu_a !== 32'd0) $display("FAIL reset_alu_a got %h want 0", ex_alu_a); else passed++;
        step();
        rst_n = 1;
        // lw $4 in EX, then a dependent decode; reset mid-run must clear immediately
        id_valid = 1; id_mem_to_reg = 1; id_reg_write = 1; id_rt = 4; id_rs = 2; id_alu_src = 1;
        step();
        id_mem_to_reg = 0; id_rs = 4; id_rt = 9;
        #1;
        total++; if (load_use_stall !== 1'b1) $display("FAIL pre_reset_stall got %0b want 1", load_use_stall); else passed++;
        #1;
        rst_n = 0;
        #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL async_reset_valid got %0b want 0", ex_valid); else passed++;
        total++; if (ex_reg_write !== 1'b0) $display("FAIL async_reset_reg_write got %0b want 0", ex_reg_write); else passed++;
        total++; if (ex_dst !== 5'd0) $display("FAIL async_reset_dst got %0d want 0", ex_dst); else passed++;
        total++; if (load_use_stall !== 1'b0) $display("FAIL async_reset_stall got %0b want 0", load_use_stall); else passed++;
        step();
        rst_n = 1;
        idle_inputs();
        step();
    endtask

    task automatic test_plain_load();
        idle_inputs();
        id_valid = 1; id_rd1 = 32'h11; id_rd2 = 32'h22; id_rs = 1; id_rt = 5; id_rd = 7;
        id_reg_dst = 1; id_imm = 16'h8000; id_alu_src = 1; id_reg_write = 1; id_alu_ctrl = 4'h2;
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL plain_valid got %0b want 1", ex_valid); else passed++;
        total++; if (ex_dst !== 5'd7) $display("FAIL plain_dst got %0d want 7", ex_dst); else passed++;
        total++; if (ex_alu_a !== 32'h11) $display("FAIL plain_alu_a got %h want 11", ex_alu_a); else passed++;
        total++; if (ex_alu_b !== 32'hFFFF8000) $display("FAIL plain_alu_b got %h want ffff8000", ex_alu_b); else passed++;
        total++; if (ex_store_data !== 32'h22) $display("FAIL plain_store got %h want 22", ex_store_data); else passed++;
        total++; if (ex_alu_ctrl !== 4'h2) $display("FAIL plain_alu_ctrl got %h want 2", ex_alu_ctrl); else passed++;
        // rt as destination, positive immediate
        id_reg_dst = 0; id_imm = 16'h7FFF;
        step();
        total++; if (ex_dst !== 5'd5) $display("FAIL rt_dst got %0d want 5", ex_dst); else passed++;
        total++; if (ex_alu_b !== 32'h00007FFF) $display("FAIL pos_imm got %h want 00007fff", ex_alu_b); else passed++;
    endtask

    task automatic test_fwd_priority();
        idle_inputs();
        id_valid = 1; id_rs = 3; id_rt = 6; id_rd1 = 32'h1234; id_rd2 = 32'h5678; id_reg_write = 1;
        step();
        exmem_reg_write = 1; exmem_dst = 3; exmem_result = 32'hAAAA;
        memwb_reg_write = 1; memwb_dst = 3; memwb_result = 32'hBBBB;
        #1;
        total++; if (ex_alu_a !== 32'hAAAA) $display("FAIL fwd_exmem_wins got %h want aaaa", ex_alu_a); else passed++;
        exmem_reg_write = 0;
        #1;
        total++; if (ex_alu_a !== 32'hBBBB) $display("FAIL fwd_memwb got %h want bbbb", ex_alu_a); else passed++;
        exmem_reg_write = 1; exmem_dst = 0; memwb_dst = 0;
        #1;
        total++; if (ex_alu_a !== 32'h1234) $display("FAIL fwd_none got %h want 1234", ex_alu_a); else passed++;
        memwb_dst = 6;
        #1;
        total++; if (ex_store_data !== 32'hBBBB) $display("FAIL fwd_rt_store got %h want bbbb", ex_store_data); else passed++;
        total++; if (ex_alu_b !== 32'hBBBB) $display("FAIL fwd_rt_alu_b got %h want bbbb", ex_alu_b); else passed++;
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_valid = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_src = 1; id_rs = 2; id_rt = 4;
        step();
        id_mem_to_reg = 0; id_alu_src = 0; id_rs = 4; id_rt = 9; id_rd = 10; id_reg_dst = 1;
        id_rd1 = 32'h0; id_rd2 = 32'h99;
        #1;
        total++; if (load_use_stall !== 1'b1) $display("FAIL lu_stall got %0b want 1", load_use_stall); else passed++;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got %0b want 0", ex_valid); else passed++;
        total++; if (ex_reg_write !== 1'b0) $display("FAIL lu_bubble_rw got %0b want 0", ex_reg_write); else passed++;
        total++; if (load_use_stall !== 1'b0) $display("FAIL lu_stall_drop got %0b want 0", load_use_stall); else passed++;
        memwb_reg_write = 1; memwb_dst = 4; memwb_result = 32'hCAFE;
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL lu_add_valid got %0b want 1", ex_valid); else passed++;
        total++; if (ex_dst !== 5'd10) $display("FAIL lu_add_dst got %0d want 10", ex_dst); else passed++;
        total++; if (ex_alu_a !== 32'hCAFE) $display("FAIL lu_add_fwd got %h want cafe", ex_alu_a); else passed++;
    endtask

    task automatic test_flush_hold();
        idle_inputs();
        id_valid = 1; id_reg_write = 1; id_reg_dst = 1; id_rd = 12; id_rs = 1; id_rd1 = 32'h100;
        flush = 1;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", ex_valid); else passed++;
        total++; if (ex_reg_write !== 1'b0) $display("FAIL flush_rw got %0b want 0", ex_reg_write); else passed++;
        flush = 0; id_rd = 13;
        step();
        total++; if (ex_dst !== 5'd13) $display("FAIL after_flush_dst got %0d want 13", ex_dst); else passed++;
        hold = 1; flush = 1; id_rd = 20; id_rd1 = 32'h200; id_rs = 2;
        step();
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL hold_valid got %0b want 1", ex_valid); else passed++;
        total++; if (ex_reg_write !== 1'b1) $display("FAIL hold_rw got %0b want 1", ex_reg_write); else passed++;
        total++; if (ex_dst !== 5'd13) $display("FAIL hold_dst got %0d want 13", ex_dst); else passed++;
        total++; if (ex_alu_a !== 32'h100) $display("FAIL hold_alu_a got %h want 100", ex_alu_a); else passed++;
        // forwarding stays live while frozen
        exmem_reg_write = 1; exmem_dst = 1; exmem_result = 32'hD00D;
        #1;
        total++; if (ex_alu_a !== 32'hD00D) $display("FAIL hold_fwd got %h want d00d", ex_alu_a); else passed++;
        hold = 0; flush = 0; exmem_reg_write = 0;
        step();
        total++; if (ex_dst !== 5'd20) $display("FAIL release_dst got %0d want 20", ex_dst); else passed++;
    endtask

    task automatic test_reg_zero();
        idle_inputs();
        id_valid = 1; id_rt = 0; id_rd2 = 32'h77; id_reg_write = 1;
        step();
        exmem_reg_write = 1; exmem_dst = 0; exmem_result = 32'h5;
        memwb_reg_write = 1; memwb_dst = 0; memwb_result = 32'h6;
        #1;
        total++; if (ex_store_data !== 32'h77) $display("FAIL zero_store got %h want 77", ex_store_data); else passed++;
        // load into $0 must not trigger a stall
        idle_inputs();
        id_valid = 1; id_mem_to_reg = 1; id_reg_write = 1; id_rt = 0;
        step();
        id_mem_to_reg = 0; id_rs = 0;
        #1;
        total++; if (load_use_stall !== 1'b0) $display("FAIL zero_stall got %0b want 0", load_use_stall); else passed++;
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        id_valid = 1; id_reg_write = 1; id_reg_dst = 1; id_rd = 8; id_rd1 = 32'hA1;
        step();
        total++; if (ex_dst !== 5'd8) $display("FAIL b2b_first_dst got %0d want 8", ex_dst); else passed++;
        id_rd = 9; id_rd1 = 32'hA2; id_mem_write = 1; id_reg_write = 0;
        step();
        total++; if (ex_dst !== 5'd9) $display("FAIL b2b_second_dst got %0d want 9", ex_dst); else passed++;
        total++; if (ex_mem_write !== 1'b1) $display("FAIL b2b_mem_write got %0b want 1", ex_mem_write); else passed++;
        total++; if (ex_alu_a !== 32'hA2) $display("FAIL b2b_alu_a got %h want a2", ex_alu_a); else passed++;
        id_valid = 0;
        step();
        total++; if (ex_mem_write !== 1'b0) $display("FAIL invalid_gate got %0b want 0", ex_mem_write); else passed++;
    endtask

    initial begin
        test_reset();
        test_plain_load();
        test_fwd_priority();
        test_load_use();
        test_flush_hold();
        test_reg_zero();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
